// File: rtl/id_branch_control_if.sv
// ID-stage branch/jump control bus: decode, operands and targets in; PC mux and pipeline enables out.
interface id_branch_control_if;
  logic        Branch_EQ_ID;
  logic        Branch_NE_ID;
  logic        Jump_ID;
  logic [31:0] Operand_A_ID;
  logic [31:0] Operand_B_ID;
  logic [1:0]  Stall_Cycles_ID;
  logic [31:0] Branch_Dest_ID;
  logic [31:0] Jump_Dest_ID;
  logic [31:0] PC_Plus_4_IF;
  logic [31:0] Next_PC_IF;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_Flush;
  logic        ID_EX_Bubble;
  logic [15:0] Taken_Count;

  modport master (
    output Branch_EQ_ID, Branch_NE_ID, Jump_ID, Operand_A_ID, Operand_B_ID,
           Stall_Cycles_ID, Branch_Dest_ID, Jump_Dest_ID, PC_Plus_4_IF,
    input  Next_PC_IF, PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, Taken_Count
  );

  modport slave (
    input  Branch_EQ_ID, Branch_NE_ID, Jump_ID, Operand_A_ID, Operand_B_ID,
           Stall_Cycles_ID, Branch_Dest_ID, Jump_Dest_ID, PC_Plus_4_IF,
    output Next_PC_IF, PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, Taken_Count
  );
endinterface

// File: rtl/id_branch_control.sv
// Resolves branches/jumps in ID; same-cycle redirect when operands are ready, otherwise stalls
// for the hazard unit's cycle count and resolves with the latched branch type.
module id_branch_control (
  input  logic               Clk,
  input  logic               Reset,
  id_branch_control_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  stall_cnt;
  logic        lat_ne;
  logic [15:0] taken_count;

  logic        ops_eq;
  logic        is_branch;
  logic        redirect;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        if_id_write;
  logic        if_flush;
  logic        id_ex_bubble;

  assign ops_eq    = (bus.Operand_A_ID == bus.Operand_B_ID);
  assign is_branch = bus.Branch_EQ_ID | bus.Branch_NE_ID;

  always_comb begin
    next_pc      = bus.PC_Plus_4_IF;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_flush     = 1'b0;
    id_ex_bubble = 1'b0;
    redirect     = 1'b0;
    if (!Reset) begin
      case (state)
        IDLE: begin
          if (bus.Jump_ID) begin
            next_pc  = bus.Jump_Dest_ID;
            if_flush = 1'b1;
            redirect = 1'b1;
          end else if (is_branch) begin
            if (bus.Stall_Cycles_ID == 2'd0) begin
              // EQ wins when both branch types are decoded
              if (bus.Branch_EQ_ID ? ops_eq : !ops_eq) begin
                next_pc  = bus.Branch_Dest_ID;
                if_flush = 1'b1;
                redirect = 1'b1;
              end
            end else begin
              pc_write     = 1'b0;
              if_id_write  = 1'b0;
              id_ex_bubble = 1'b1;
            end
          end
        end
        STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
        RESOLVE: begin
          if (lat_ne ? !ops_eq : ops_eq) begin
            next_pc  = bus.Branch_Dest_ID;
            if_flush = 1'b1;
            redirect = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      stall_cnt   <= 2'd0;
      lat_ne      <= 1'b0;
      taken_count <= 16'd0;
    end else begin
      if (redirect && taken_count != 16'hFFFF)
        taken_count <= taken_count + 16'd1;
      case (state)
        IDLE: begin
          if (!bus.Jump_ID && is_branch && bus.Stall_Cycles_ID != 2'd0) begin
            stall_cnt <= bus.Stall_Cycles_ID;
            lat_ne    <= !bus.Branch_EQ_ID;
            state     <= STALL;
          end
        end
        STALL: begin
          stall_cnt <= stall_cnt - 2'd1;
          if (stall_cnt <= 2'd1)
            state <= RESOLVE;
        end
        RESOLVE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Next_PC_IF   = next_pc;
  assign bus.PC_Write     = pc_write;
  assign bus.IF_ID_Write  = if_id_write;
  assign bus.IF_Flush     = if_flush;
  assign bus.ID_EX_Bubble = id_ex_bubble;
  assign bus.Taken_Count  = taken_count;

endmodule

// File: tb/tb_id_branch_control.sv
// Directed vector table for same-cycle decisions plus hand sequences for stall, reset and saturation.
module tb_id_branch_control;

  localparam logic [31:0] PC4  = 32'h0000_1004;
  localparam logic [31:0] BDST = 32'h0000_0400;
  localparam logic [31:0] JDST = 32'h0000_8000;

  logic Clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] exp_count;

  id_branch_control_if bus ();

  id_branch_control dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        jump, beq, bne;
    logic [31:0] a, b;
    logic [1:0]  stall;
    logic [31:0] exp_pc;
    logic        exp_flush;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic j, input logic eq, input logic ne,
                       input logic [31:0] a, input logic [31:0] b, input logic [1:0] st);
    bus.Jump_ID         = j;
    bus.Branch_EQ_ID    = eq;
    bus.Branch_NE_ID    = ne;
    bus.Operand_A_ID    = a;
    bus.Operand_B_ID    = b;
    bus.Stall_Cycles_ID = st;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_normal(input string nm);
    chk({nm, "_pc"},    bus.Next_PC_IF, PC4);
    chk({nm, "_pcw"},   {31'd0, bus.PC_Write}, 32'd1);
    chk({nm, "_ifid"},  {31'd0, bus.IF_ID_Write}, 32'd1);
    chk({nm, "_flush"}, {31'd0, bus.IF_Flush}, 32'd0);
    chk({nm, "_bub"},   {31'd0, bus.ID_EX_Bubble}, 32'd0);
  endtask

  task automatic chk_stall(input string nm);
    chk({nm, "_pc"},    bus.Next_PC_IF, PC4);
    chk({nm, "_pcw"},   {31'd0, bus.PC_Write}, 32'd0);
    chk({nm, "_ifid"},  {31'd0, bus.IF_ID_Write}, 32'd0);
    chk({nm, "_flush"}, {31'd0, bus.IF_Flush}, 32'd0);
    chk({nm, "_bub"},   {31'd0, bus.ID_EX_Bubble}, 32'd1);
  endtask

  task automatic chk_redirect(input string nm, input logic [31:0] dst);
    chk({nm, "_pc"},    bus.Next_PC_IF, dst);
    chk({nm, "_pcw"},   {31'd0, bus.PC_Write}, 32'd1);
    chk({nm, "_flush"}, {31'd0, bus.IF_Flush}, 32'd1);
    chk({nm, "_bub"},   {31'd0, bus.ID_EX_Bubble}, 32'd0);
  endtask

  initial begin
    //          jump  beq   bne   a              b              st    exp_pc fl
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         2'd0, PC4,  1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h1234,      32'h1234,      2'd0, BDST, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'd5,         32'd5,         2'd0, PC4,  1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'd5,         32'd6,         2'd0, BDST, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0,         2'd0, PC4,  1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'd7,         32'd7,         2'd0, BDST, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'd7,         32'd8,         2'd0, PC4,  1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'd1,         32'd1,         2'd3, JDST, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'd1,         32'd2,         2'd2, JDST, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'd3,         32'd3,         2'd0, JDST, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2'd0, PC4,  1'b0};

    bus.PC_Plus_4_IF   = PC4;
    bus.Branch_Dest_ID = BDST;
    bus.Jump_Dest_ID   = JDST;

    // Reset cycle with a jump decoded: outputs must still look control-free
    Reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'd1, 32'd1, 2'd0);
    chk_normal("rst_out");
    tick();
    tick();
    chk("rst_count", {16'd0, bus.Taken_Count}, 32'd0);
    Reset = 1'b0;
    exp_count = 16'd0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].jump, vecs[i].beq, vecs[i].bne, vecs[i].a, vecs[i].b, vecs[i].stall);
      chk($sformatf("v%0d_pc", i), bus.Next_PC_IF, vecs[i].exp_pc);
      chk($sformatf("v%0d_flush", i), {31'd0, bus.IF_Flush}, {31'd0, vecs[i].exp_flush});
      chk($sformatf("v%0d_pcw", i), {31'd0, bus.PC_Write}, 32'd1);
      chk($sformatf("v%0d_bub", i), {31'd0, bus.ID_EX_Bubble}, 32'd0);
      if (vecs[i].exp_flush) exp_count = exp_count + 16'd1;
      tick();
      chk($sformatf("v%0d_count", i), {16'd0, bus.Taken_Count}, {16'd0, exp_count});
    end

    // beq with 2 stall cycles; inputs scrambled during STALL must not matter
    drive(1'b0, 1'b1, 1'b0, 32'd1, 32'd2, 2'd2);
    chk_stall("s2_detect");
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'd9, 32'd9, 2'd3);
    chk_stall("s2_stall1");
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd9, 32'd8, 2'd1);
    chk_stall("s2_stall2");
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'hABCD, 32'hABCD, 2'd3);
    chk_redirect("s2_resolve", BDST);
    exp_count = exp_count + 16'd1;
    tick();
    chk("s2_count", {16'd0, bus.Taken_Count}, {16'd0, exp_count});
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    chk_normal("s2_after");
    tick();

    // bne with 1 stall cycle, operands equal at resolve: not taken
    drive(1'b0, 1'b0, 1'b1, 32'd3, 32'd4, 2'd1);
    chk_stall("s1_detect");
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd4, 2'd0);
    chk_stall("s1_stall1");
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd4, 32'd4, 2'd0);
    chk_normal("s1_resolve");
    tick();
    chk("s1_count", {16'd0, bus.Taken_Count}, {16'd0, exp_count});
    drive(1'b0, 1'b0, 1'b0, 32'd4, 32'd4, 2'd0);
    chk_normal("s1_after");
    tick();

    // Reset in the middle of a 3-cycle stall discards the pending beq
    drive(1'b0, 1'b1, 1'b0, 32'd1, 32'd2, 2'd3);
    chk_stall("rs_detect");
    tick();
    chk_stall("rs_stall1");
    Reset = 1'b1;
    #1;
    chk_normal("rs_during");
    tick();
    Reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd5, 32'd5, 2'd0);
    chk("rs_count", {16'd0, bus.Taken_Count}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk_normal($sformatf("rs_idle%0d", i));
      tick();
    end
    chk("rs_count_hold", {16'd0, bus.Taken_Count}, 32'd0);

    // Saturation: 65535 jumps fill the counter, one more leaves it pinned
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_65534", {16'd0, bus.Taken_Count}, 32'h0000_FFFE);
    tick();
    chk("sat_full", {16'd0, bus.Taken_Count}, 32'h0000_FFFF);
    chk_redirect("sat_jump", JDST);
    tick();
    chk("sat_hold", {16'd0, bus.Taken_Count}, 32'h0000_FFFF);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_branch_control.md
ID_BRANCH_CONTROL -- requirements
Module: id_branch_control

Interface
REQ-001 SHALL have ports: Clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have Branch_EQ_ID  in  1  beq decoded in ID.
REQ-004 SHALL have Branch_NE_ID  in  1  bne decoded in ID.
REQ-005 SHALL have Jump_ID  in  1  j/jal decoded in ID.
REQ-006 SHALL have Operand_A_ID, Operand_B_ID  in  32 each  forwarded compare operands.
REQ-007 SHALL have Stall_Cycles_ID  in  2  cycles until operands valid (0-3), from hazard unit.
REQ-008 SHALL have Branch_Dest_ID  in  32  PC+4 plus shifted immediate (ID branch adder).
REQ-009 SHALL have Jump_Dest_ID  in  32  jump target.
REQ-010 SHALL have PC_Plus_4_IF  in  32  sequential next PC.
REQ-011 SHALL have Next_PC_IF  out  32  PC mux result.
REQ-012 SHALL have PC_Write, IF_ID_Write  out  1 each  enable PC / IF-ID register.
REQ-013 SHALL have IF_Flush  out  1  zero IF/ID on redirect.
REQ-014 SHALL have ID_EX_Bubble  out  1  insert nop into ID/EX.
REQ-015 SHALL have Taken_Count  out  16  saturating count of redirects.

Function
REQ-016 SHALL implement states IDLE, STALL, RESOLVE in a 2-bit registered state.
REQ-017 Control-free cycle (no Branch/Jump) in IDLE: Next_PC_IF=PC_Plus_4_IF, PC_Write=1, IF_ID_Write=1, IF_Flush=0, ID_EX_Bubble=0.
REQ-018 Jump_ID in IDLE SHALL redirect same cycle: Next_PC_IF=Jump_Dest_ID, IF_Flush=1, PC_Write=1; Stall_Cycles_ID ignored; state stays IDLE.
REQ-019 Jump_ID SHALL take priority over Branch_EQ_ID/Branch_NE_ID; Branch_EQ_ID over Branch_NE_ID when both set.
REQ-020 Branch in IDLE with Stall_Cycles_ID=0 SHALL resolve same cycle: taken = (A==B) for EQ, (A!=B) for NE.
REQ-021 Taken resolve: Next_PC_IF=Branch_Dest_ID, IF_Flush=1, PC_Write=1; not taken: REQ-017 outputs.
REQ-022 Branch in IDLE with Stall_Cycles_ID=N>0 SHALL latch N into a 2-bit down-counter and latch branch type, go to STALL next edge.
REQ-023 The detecting cycle and every STALL cycle SHALL drive PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_Flush=0, Next_PC_IF=PC_Plus_4_IF.
REQ-024 STALL SHALL decrement counter each cycle; when counter==1 next state RESOLVE (total stall cycles = N).
REQ-025 Stall_Cycles_ID, Branch_*_ID changes SHALL be ignored while in STALL; latched type used.
REQ-026 RESOLVE SHALL compare current Operand_A_ID/Operand_B_ID with latched type, drive REQ-021 outputs, return to IDLE next edge; never stalls again.
REQ-027 Taken_Count SHALL increment by 1 on every taken branch or jump redirect, saturate at 16'hFFFF.
REQ-028 Compare SHALL be full 32-bit unsigned equality; no arithmetic on targets inside block.

Reset
REQ-029 Reset SHALL force state IDLE, counter 0, latched type 0, Taken_Count 0 on the next edge, including mid-STALL.
REQ-030 During a Reset cycle outputs SHALL equal REQ-017 values (Next_PC_IF=PC_Plus_4_IF, PC_Write=1, others 0).
REQ-031 A branch pending at reset SHALL be discarded, never resolved.

Verification
REQ-032 beq, A=B=0x1234, Stall=0, Branch_Dest=0x400 -> same cycle Next_PC=0x400, IF_Flush=1, Taken_Count 0->1.
REQ-033 bne, A=5, B=5, Stall=0 -> Next_PC=PC_Plus_4_IF, IF_Flush=0, count unchanged.
REQ-034 beq, Stall=2, A becomes equal in RESOLVE -> PC_Write=0/Bubble=1 for 3 cycles (detect + 2 STALL... per REQ-023/024: detect cycle then STALL cycles until RESOLVE), then RESOLVE cycle redirect with IF_Flush=1; stall inputs toggled during STALL have no effect.
REQ-035 Jump_ID and Branch_EQ_ID together, Stall=3 -> immediate redirect to Jump_Dest_ID, no stall.
REQ-036 Reset asserted in STALL -> next cycle IDLE, PC_Write=1, no redirect, Taken_Count=0.
REQ-037 Force Taken_Count to 0xFFFF via 65535 jumps, one more jump -> stays 0xFFFF.
